// File: rtl/num_chk.sv
// ---------------------------------------------------------------------------
// num_chk
//
// Receive-side test-pattern checker for the serdes stream test path. It pulls
// bytes from the RX FIFO and checks that they follow a modulo-256 incrementing
// sequence. It hunts for the sequence, declares lock after a run of good words,
// counts mismatches while locked, and drops lock after persistent corruption.
//
// Parameters
//   LOCK_CNT  consecutive matching words needed to enter TRACK (1..15)
//   LOSS_CNT  consecutive mismatching words in TRACK that force HUNT (1..15)
//
// Ports
//   clk        in   1   clock, everything on the rising edge
//   res        in   1   synchronous active-high reset
//   en         in   1   read enable; 0 pauses reads, state is kept
//   clr        in   1   pulse: zero err_cnt and word_cnt (lock state kept)
//   data       in   8   FIFO read data, valid the cycle after rd_en
//   empty      in   1   FIFO empty flag
//   rd_en      out  1   FIFO read strobe (combinational)
//   locked     out  1   high while in TRACK
//   err_pulse  out  1   one-cycle strobe per mismatched word in TRACK
//   err_cnt    out  16  mismatches seen in TRACK, saturating
//   word_cnt   out  32  words checked in TRACK, wrapping
// ---------------------------------------------------------------------------
module num_chk #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  data,
  input  logic        empty,
  output logic        rd_en,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] word_cnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_RUN = LOCK_CNT[3:0];
  localparam logic [3:0] LOSS_RUN = LOSS_CNT[3:0];

  state_t      state_reg;
  logic        vld_reg;
  logic [7:0]  exp_reg;
  logic [3:0]  run_reg;
  logic        locked_reg;
  logic        err_pulse_reg;
  logic [15:0] err_cnt_reg;
  logic [31:0] word_cnt_reg;

  logic       match;
  logic [3:0] run_inc;

  // Reads are suppressed during reset so no word is pulled from the FIFO
  // that the checker would then have to discard.
  assign rd_en = en & ~empty & ~res;

  assign match   = (data == exp_reg);
  // run never exceeds 14 before it is compared, so this cannot wrap.
  assign run_inc = run_reg + 4'd1;

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg     <= HUNT;
      vld_reg       <= 1'b0;
      exp_reg       <= 8'd0;
      run_reg       <= 4'd0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= 16'd0;
      word_cnt_reg  <= 32'd0;
    end else begin
      vld_reg       <= rd_en;
      err_pulse_reg <= 1'b0;

      if (vld_reg) begin
        // Always re-seed the expectation from the word just seen, so a single
        // corrupted byte costs two mismatches and then the check resyncs.
        exp_reg <= data + 8'd1;

        case (state_reg)
          HUNT: begin
            run_reg   <= 4'd0;
            state_reg <= SYNC;
          end

          SYNC: begin
            if (match) begin
              if (run_inc == LOCK_RUN) begin
                state_reg  <= TRACK;
                locked_reg <= 1'b1;
                run_reg    <= 4'd0;
              end else begin
                run_reg <= run_inc;
              end
            end else begin
              run_reg <= 4'd0;
            end
          end

          TRACK: begin
            word_cnt_reg <= word_cnt_reg + 32'd1;
            if (match) begin
              run_reg <= 4'd0;
            end else begin
              err_pulse_reg <= 1'b1;
              if (err_cnt_reg != 16'hFFFF)
                err_cnt_reg <= err_cnt_reg + 16'd1;
              if (run_inc == LOSS_RUN) begin
                state_reg  <= HUNT;
                locked_reg <= 1'b0;
                run_reg    <= 4'd0;
              end else begin
                run_reg <= run_inc;
              end
            end
          end

          default: begin
            state_reg  <= HUNT;
            locked_reg <= 1'b0;
            run_reg    <= 4'd0;
          end
        endcase
      end

      // Placed last so a clear wins over any increment in the same cycle;
      // err_pulse is deliberately left alone.
      if (clr) begin
        err_cnt_reg  <= 16'd0;
        word_cnt_reg <= 32'd0;
      end
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_cnt   = err_cnt_reg;
  assign word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_num_chk.sv
// ---------------------------------------------------------------------------
// tb_num_chk
//
// Self-checking bench for num_chk. A queue stands in for the RX FIFO; a
// word-level reference model (previous byte, good/bad streak counters) gives
// the expected outputs after every clock. Directed sections follow the test
// plan: lock-up, wrap, single corruption, loss of lock, stalls, clear, reset.
// ---------------------------------------------------------------------------
module tb_num_chk;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 8;

  logic        clk = 1'b0;
  logic        res;
  logic        en;
  logic        clr;
  logic [7:0]  data;
  logic        empty;
  logic        rd_en;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;

  always #5 clk = ~clk;

  num_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk       (clk),
    .res       (res),
    .en        (en),
    .clr       (clr),
    .data      (data),
    .empty     (empty),
    .rd_en     (rd_en),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  bit         fired = 1'b0;
  int         reads = 0;
  int         pulses = 0;

  // Reference model state: plain word-level view of the stream.
  bit          m_locked;
  bit          m_have_prev;
  bit          m_pulse;
  int          m_prev;
  int          m_good;
  int          m_bad_run;
  int          m_err;
  logic [31:0] m_wc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_have_prev = 0; m_pulse = 0;
    m_prev = 0; m_good = 0; m_bad_run = 0; m_err = 0; m_wc = '0;
  endtask

  task automatic model_word(input int d);
    bit ok;
    bit lost;
    ok   = m_have_prev && (d == (m_prev + 1) % 256);
    lost = 0;
    if (!m_locked) begin
      if (!m_have_prev)  m_good = 0;
      else if (ok)       m_good = m_good + 1;
      else               m_good = 0;
      if (m_good == LOCK_CNT) begin
        m_locked  = 1;
        m_bad_run = 0;
      end
    end else begin
      m_wc = m_wc + 32'd1;
      if (ok) begin
        m_bad_run = 0;
      end else begin
        m_pulse = 1;
        if (m_err < 65535) m_err = m_err + 1;
        m_bad_run = m_bad_run + 1;
        if (m_bad_run == LOSS_CNT) begin
          m_locked = 0;
          lost     = 1;
        end
      end
    end
    m_prev      = d;
    m_have_prev = !lost;
  endtask

  // One clock: deliver any word read last cycle, drive inputs, check the
  // read strobe mid-cycle, then compare outputs just after the edge.
  task automatic step(input bit en_v, input int stall_pct, input bit clr_v, input bit res_v);
    m_pulse = 0;
    if (fired) begin
      data = q.pop_front();
      if (res_v) model_reset();
      else       model_word(int'(data));
    end else if (res_v) begin
      model_reset();
    end
    if (clr_v && !res_v) begin
      m_err = 0;
      m_wc  = '0;
    end
    en    = en_v;
    clr   = clr_v;
    res   = res_v;
    empty = (q.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    @(negedge clk);
    chk("rd_en", 32'(rd_en), 32'(en & ~empty & ~res));
    fired = rd_en && (q.size() > 0);
    if (rd_en) reads++;
    @(posedge clk);
    #1;
    chk("locked",    32'(locked),    32'(m_locked));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
    chk("word_cnt",  word_cnt,       m_wc);
    if (err_pulse) pulses++;
    clr = 1'b0;
  endtask

  task automatic drain(input int stall_pct, input bit rand_en);
    int n;
    n = 0;
    while ((q.size() > 0 || fired) && n < 2000) begin
      step(rand_en ? ($urandom_range(0, 3) != 0) : 1'b1, stall_pct, 1'b0, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic push_seq(input int start, input int n);
    for (int i = 0; i < n; i++) q.push_back(8'((start + i) % 256));
  endtask

  initial begin
    int          k;
    int          rd5_step;
    int          lock_step;
    logic [31:0] wc0;
    logic [7:0]  prev;
    logic [7:0]  r;
    logic [7:0]  s;
    logic [7:0]  badw;

    res = 1'b1; en = 1'b1; clr = 1'b0; empty = 1'b1; data = 8'd0;
    model_reset();

    // Reset: FIFO has data and en=1, yet no read may issue.
    push_seq(0, 16);
    repeat (3) step(1'b1, 0, 1'b0, 1'b1);
    chk("rst_locked",  32'(locked),   32'd0);
    chk("rst_err_cnt", 32'(err_cnt),  32'd0);
    chk("rst_wc",      word_cnt,      32'd0);

    // Clean 00..0F stream: lock timing and final counts.
    reads = 0; rd5_step = -1; lock_step = -1; k = 0;
    while ((q.size() > 0 || fired) && k < 100) begin
      step(1'b1, 0, 1'b0, 1'b0);
      k++;
      if (reads == 5 && rd5_step < 0) rd5_step = k;
      if (locked && lock_step < 0)    lock_step = k;
    end
    step(1'b1, 0, 1'b0, 1'b0);
    chk("lock_latency", 32'(lock_step - rd5_step), 32'd1);
    chk("s1_locked", 32'(locked),  32'd1);
    chk("s1_err",    32'(err_cnt), 32'd0);
    chk("s1_wc",     word_cnt,     32'd11);

    // Continue to FC, then FD,FE,FF,00,01 across the wrap.
    push_seq(16, 253 - 16);
    drain(0, 1'b0);
    wc0 = word_cnt; pulses = 0;
    push_seq(253, 5);
    drain(0, 1'b0);
    chk("wrap_wc",     word_cnt - wc0, 32'd5);
    chk("wrap_pulses", 32'(pulses),    32'd0);

    // Single corruption: ...10,11,55,13,14,15,16.
    step(1'b1, 0, 1'b1, 1'b0);
    pulses = 0;
    push_seq(2, 16);
    q.push_back(8'h55);
    push_seq(8'h13, 4);
    drain(0, 1'b0);
    chk("corr_pulses", 32'(pulses),  32'd2);
    chk("corr_err",    32'(err_cnt), 32'd2);
    chk("corr_locked", 32'(locked),  32'd1);

    // Loss of lock: LOSS_CNT random words, each mismatching its predecessor.
    step(1'b1, 0, 1'b1, 1'b0);
    pulses = 0;
    prev = 8'h16;
    for (int i = 0; i < LOSS_CNT; i++) begin
      do r = 8'($urandom_range(0, 255)); while (r == 8'(prev + 8'd1));
      q.push_back(r);
      prev = r;
    end
    drain(0, 1'b0);
    chk("loss_locked", 32'(locked),  32'd0);
    chk("loss_err",    32'(err_cnt), 32'(LOSS_CNT));
    chk("loss_pulses", 32'(pulses),  32'(LOSS_CNT));
    s = 8'($urandom_range(0, 255));
    push_seq(int'(s), 5);
    drain(0, 1'b0);
    chk("relock", 32'(locked), 32'd1);

    // Stalls and pauses on a clean stream.
    step(1'b1, 0, 1'b1, 1'b0);
    reads = 0;
    push_seq(int'(s) + 5, 40);
    drain(30, 1'b1);
    chk("stall_reads", 32'(reads),   32'd40);
    chk("stall_wc",    word_cnt,     32'd40);
    chk("stall_err",   32'(err_cnt), 32'd0);

    // Clear coincident with a bad word.
    badw = 8'(int'(s) + 45 + 1 + $urandom_range(0, 250));
    q.push_back(badw);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b1, 1'b0);
    chk("clr_err",   32'(err_cnt),   32'd0);
    chk("clr_pulse", 32'(err_pulse), 32'd1);
    chk("clr_wc",    word_cnt,       32'd0);
    push_seq(int'(badw) + 1, 3);
    drain(0, 1'b0);

    // Reset mid-stream, then relock on the remainder.
    push_seq(int'(badw) + 4, 10);
    repeat (3) step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1);
    chk("mrst_locked", 32'(locked),  32'd0);
    chk("mrst_err",    32'(err_cnt), 32'd0);
    chk("mrst_wc",     word_cnt,     32'd0);
    drain(0, 1'b0);
    chk("mrst_relock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
